// File: rtl/nandn_filt.sv
// -----------------------------------------------------------------------------
// nandn_filt -- synchronised, deglitched N-input NAND
//
// Each bit of the asynchronous input bus passes through its own flop chain.
// The NAND of the synchronised bits is accepted onto the registered output
// only after it has disagreed with that output for FILT consecutive enabled
// cycles. Anything shorter is discarded.
//
// Parameters
//   N            number of NAND inputs (2..8)
//   SYNC_STAGES  synchroniser depth per input bit (1..3)
//   FILT         deglitch threshold in clock cycles (1..255)
//   CNT_W        filter counter width; must hold FILT-1
//
// Ports
//   CELCLK   in   clock, rising-edge active
//   CELRSTN  in   synchronous active-low reset
//   CELV     in   supply pin, netlisting only, no functional effect
//   CELG     in   ground pin, netlisting only, no functional effect
//   SUB      in   substrate pin, netlisting only, no functional effect
//   en       in   filter enable; while low, o holds and the count is cleared
//   i[N-1:0] in   asynchronous NAND inputs
//   o        out  filtered, registered NAND result (resets to 1)
//   chg      out  registered one-cycle pulse in the cycle o takes a new value
// -----------------------------------------------------------------------------
module nandn_filt #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 4,
    parameter int CNT_W       = 8
) (
    input  logic         CELCLK,
    input  logic         CELRSTN,
    input  logic         CELV,
    input  logic         CELG,
    input  logic         SUB,
    input  logic         en,
    input  logic [N-1:0] i,
    output logic         o,
    output logic         chg
);

    // Terminal count of the filter: the count value on which the candidate
    // result is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT - 1);

    // Power and substrate pins exist only so the netlist matches the cell
    // footprint; fold them into a name that is deliberately left unread.
    logic unused_pins;
    assign unused_pins = &{1'b0, CELV, CELG, SUB};

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] s;

    // The synchronisers run regardless of en so that, when filtering is
    // re-enabled, s already reflects the present input state.
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            // NOTE: the chain is a handful of flops, not a RAM, so every
            // stage is cleared; that keeps o consistent with s after reset.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage capture the
            // previous stage's old value, forming a true shift chain.
            sync_q[0] <= i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Raw result and deglitch filter
    // -------------------------------------------------------------------------
    logic             r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             o_d;
    logic             chg_d;

    assign r = ~&s;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch can be inferred.
        cnt_d = '0;
        o_d   = o;
        chg_d = 1'b0;

        if (en && (r != o)) begin
            if (cnt == CNT_MAX) begin
                // With FILT=1 a fresh disagreement can appear in the very
                // cycle after an update. Waiting one cycle while chg is high
                // keeps chg from ever being asserted on two adjacent cycles.
                // For FILT>1 the count is always 0 while chg is high, so this
                // guard never delays the update.
                if (!chg) begin
                    o_d   = r;
                    chg_d = 1'b1;
                end else begin
                    cnt_d = cnt;
                end
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
        // Otherwise (disabled, or r agrees with o) the count clears, which
        // throws away any partially qualified glitch.
    end

    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            cnt <= '0;
            o   <= 1'b1;   // NAND of the all-zero synchroniser state
            chg <= 1'b0;
        end else begin
            cnt <= cnt_d;
            o   <= o_d;
            chg <= chg_d;
        end
    end

endmodule

// File: tb/tb_nandn_filt.sv
// -----------------------------------------------------------------------------
// tb_nandn_filt -- scoreboard bench for nandn_filt
//
// Two instances share one clock and reset:
//   dut_a  N=3, SYNC_STAGES=2, FILT=4
//   dut_b  N=8, SYNC_STAGES=2, FILT=1
// The stimulus process drives directed vectors and pushes the hand-computed
// update (clock edge number and new o value) onto a per-instance queue. A
// monitor per instance watches for chg or any movement of o on the falling
// edge, pops the queue and compares.
// -----------------------------------------------------------------------------
module tb_nandn_filt;

    typedef struct {
        int   at_edge;
        logic o_val;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [2:0] ia;
    logic [7:0] ib;
    logic       o_a, chg_a;
    logic       o_b, chg_b;

    int   checks;
    int   errors;
    int   cyc;
    bit   mon_on;
    logic last_a;
    logic last_b;
    exp_t q_a[$];
    exp_t q_b[$];

    nandn_filt #(.N(3), .SYNC_STAGES(2), .FILT(4), .CNT_W(8)) dut_a (
        .CELCLK (clk),
        .CELRSTN(rstn),
        .CELV   (1'b1),
        .CELG   (1'b0),
        .SUB    (1'b0),
        .en     (en),
        .i      (ia),
        .o      (o_a),
        .chg    (chg_a)
    );

    nandn_filt #(.N(8), .SYNC_STAGES(2), .FILT(1), .CNT_W(8)) dut_b (
        .CELCLK (clk),
        .CELRSTN(rstn),
        .CELV   (1'b1),
        .CELG   (1'b0),
        .SUB    (1'b0),
        .en     (en),
        .i      (ib),
        .o      (o_b),
        .chg    (chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen so far; on a falling edge this is the number of the
    // edge just taken.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input int at_edge, input logic o_val);
        exp_t e;
        e.at_edge = at_edge;
        e.o_val   = o_val;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int at_edge, input logic o_val);
        exp_t e;
        e.at_edge = at_edge;
        e.o_val   = o_val;
        q_b.push_back(e);
    endtask

    // Monitors: any chg or any change of o must match the next queued update.
    // An update with nothing queued (including a second chg in a row) is an
    // error.
    always @(negedge clk) begin
        if (mon_on && (chg_a || (o_a !== last_a))) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_update o=%0b chg=%0b at edge %0d, no update queued",
                         o_a, chg_a, cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_update_edge", cyc, e.at_edge);
                check("a_update_o", int'(o_a), int'(e.o_val));
                check("a_update_chg", int'(chg_a), 1);
            end
        end
        if (mon_on) last_a = o_a;
    end

    always @(negedge clk) begin
        if (mon_on && (chg_b || (o_b !== last_b))) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_update o=%0b chg=%0b at edge %0d, no update queued",
                         o_b, chg_b, cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_update_edge", cyc, e.at_edge);
                check("b_update_o", int'(o_b), int'(e.o_val));
                check("b_update_chg", int'(chg_b), 1);
            end
        end
        if (mon_on) last_b = o_b;
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_on = 1'b0;
        last_a = 1'b1;
        last_b = 1'b1;
        rstn   = 1'b0;
        en     = 1'b0;
        ia     = 3'b000;
        ib     = 8'h00;

        // Reset state
        tick(3);
        check("rst_o_a", int'(o_a), 1);
        check("rst_chg_a", int'(chg_a), 0);
        check("rst_o_b", int'(o_b), 1);
        check("rst_chg_b", int'(chg_b), 0);
        rstn   = 1'b1;
        mon_on = 1'b1;

        // Idle with all-zero inputs: NAND is 1, nothing ever updates
        en = 1'b1;
        tick(12);
        check("idle_o_a", int'(o_a), 1);
        check("idle_cnt_a", int'(dut_a.cnt), 0);

        // Stable change 000 -> 111: o falls 2 sync + 4 filter edges after
        // the first sampling edge (edge cyc+1), i.e. on edge cyc+6
        ia = 3'b111;
        push_a(cyc + 6, 1'b0);
        tick(10);
        check("stable_fall_seen", q_a.size(), 0);
        check("stable_fall_o", int'(o_a), 0);
        ia = 3'b000;
        push_a(cyc + 6, 1'b1);
        tick(10);
        check("stable_rise_seen", q_a.size(), 0);
        check("stable_rise_o", int'(o_a), 1);

        // Glitch: three cycles of 111 reach a count of 3, one short of FILT
        ia = 3'b111;
        tick(3);
        ia = 3'b000;
        tick(12);
        check("glitch_o", int'(o_a), 1);
        check("glitch_cnt", int'(dut_a.cnt), 0);

        // Enable gating: counting is held off entirely while en=0
        en = 1'b0;
        ia = 3'b111;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("gate_o", int'(o_a), 1);
        end
        check("gate_cnt", int'(dut_a.cnt), 0);
        // s is already 111, so counting starts on the next edge: o falls
        // on edge cyc+4
        en = 1'b1;
        push_a(cyc + 4, 1'b0);
        tick(8);
        check("gate_fall_seen", q_a.size(), 0);
        check("gate_fall_o", int'(o_a), 0);
        ia = 3'b000;
        push_a(cyc + 6, 1'b1);
        tick(10);
        check("gate_rise_o", int'(o_a), 1);

        // Reset mid-count: after 4 edges the count is 2 (edge 1 samples,
        // edge 2 reaches s, edges 3 and 4 count)
        ia = 3'b111;
        tick(4);
        check("midrst_cnt_before", int'(dut_a.cnt), 2);
        rstn = 1'b0;
        tick(1);
        check("midrst_o", int'(o_a), 1);
        check("midrst_chg", int'(chg_a), 0);
        check("midrst_cnt", int'(dut_a.cnt), 0);
        // The synchronisers were cleared, so the full latency starts again
        rstn = 1'b1;
        push_a(cyc + 6, 1'b0);
        tick(10);
        check("midrst_fall_seen", q_a.size(), 0);
        check("midrst_fall_o", int'(o_a), 0);
        ia = 3'b000;
        push_a(cyc + 6, 1'b1);
        tick(10);

        // Boundary FILT=1, N=8: o updates 2 sync + 1 filter edges later
        ib = 8'hff;
        push_b(cyc + 3, 1'b0);
        tick(6);
        check("b_setup_o", int'(o_b), 0);
        for (int k = 0; k < 3; k++) begin
            int bitn;
            bitn = (k == 0) ? 3 : ((k == 1) ? 0 : 7);
            ib[bitn] = 1'b0;
            push_b(cyc + 3, 1'b1);
            tick(5);
            check("b_toggle_hi_o", int'(o_b), 1);
            ib[bitn] = 1'b1;
            push_b(cyc + 3, 1'b0);
            tick(5);
            check("b_toggle_lo_o", int'(o_b), 0);
        end

        tick(4);
        check("end_queue_a", q_a.size(), 0);
        check("end_queue_b", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nandn_filt.md
NANDN_FILT -- requirements
Module: nandn_filt

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the number of NAND inputs; legal range 2..8.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth; legal range 1..3.
REQ-003 The block SHALL have parameter FILT, default 4, giving the deglitch threshold in clock cycles; legal range 1..255.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the filter counter width; CNT_W SHALL be large enough to hold FILT-1.
REQ-005 Port CELCLK, input, 1 bit: the single clock, rising-edge active.
REQ-006 Port CELRSTN, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port CELV, input, 1 bit: supply pin, carried for netlisting only, with no functional effect.
REQ-008 Port CELG, input, 1 bit: ground pin, carried for netlisting only, with no functional effect.
REQ-009 Port SUB, input, 1 bit: substrate pin, carried for netlisting only, with no functional effect.
REQ-010 Port en, input, 1 bit: filter enable.
REQ-011 Port i, input, N bits: asynchronous NAND inputs.
REQ-012 Port o, output, 1 bit: filtered, registered NAND result.
REQ-013 Port chg, output, 1 bit: one-cycle pulse marking an update of o.

Function
REQ-014 Each bit of i SHALL pass through its own SYNC_STAGES-deep flop chain; the last stage is s[N-1:0].
REQ-015 The raw result r SHALL equal the NAND of all bits of s (~&s); r is combinational and internal only.
REQ-016 While en=1 and r differs from o, the counter cnt SHALL increment by 1 each cycle.
REQ-017 On the cycle where en=1, r differs from o and cnt equals FILT-1, the block SHALL:
- load o with r;
- clear cnt to 0;
- assert chg for exactly that following cycle.
REQ-018 Whenever r equals o, cnt SHALL clear to 0 on the next edge, so any glitch shorter than FILT cycles is discarded entirely.
REQ-019 While en=0:
- o SHALL hold its value;
- cnt SHALL clear to 0;
- chg SHALL be 0;
- the synchronisers SHALL keep running.
REQ-020 With FILT=1, o SHALL update on the first edge at which r differs from o.
REQ-021 Latency from a stable change on i to o SHALL be SYNC_STAGES+FILT rising edges, measured from the first edge that samples the new value.
REQ-022 cnt SHALL never exceed FILT-1 and SHALL never wrap.
REQ-023 chg SHALL be a registered output and SHALL never be high for two consecutive cycles.
REQ-024 When en rises while r differs from o, counting SHALL start from 0 on that cycle.

Reset
REQ-025 While CELRSTN=0 at a rising edge, the block SHALL reset as follows:
- all synchroniser flops to 0;
- cnt to 0;
- o to 1 (the NAND of all zeros);
- chg to 0.
REQ-026 Reset SHALL take priority over en and over any count in progress; an assertion mid-count SHALL abandon the count, and no chg SHALL be issued.
REQ-027 After release, the block SHALL resume normal operation at the first edge with CELRSTN=1.

Verification
REQ-028 The bench SHALL cover these directed scenarios, with N=3, SYNC_STAGES=2, FILT=4:
- Reset then idle: i=3'b000 -> o=1 and chg=0 held indefinitely.
- Stable change: en=1, i goes 000 to 111 -> o falls exactly 6 edges after the first sampling edge; chg pulses once, in the same cycle o changes.
- Glitch: en=1, i=111 for 3 cycles, then back to 000 -> o stays 1 and chg never asserts.
- Enable gating: i=111 with en=0 for 20 cycles -> o=1 throughout; en then raised -> o falls 4 edges later.
- Reset mid-count: i=111, CELRSTN pulsed low at filter count 2 -> o=1, cnt=0, no chg; with CELRSTN high and i still 111, o falls 6 edges later.
- Boundary, FILT=1 and N=8: a single-bit change on i -> o toggles after 3 edges, with one chg pulse per toggle.
